// File: rtl/pet2001_prg_loader_pkg.sv
// pet2001_loader_pkg: loader states and constants; PRG_AUTORUN_EN adds the KBD state and its keyboard-buffer constants
package pet2001_loader_pkg;
`ifdef PRG_AUTORUN_EN
  typedef enum logic [2:0] {IDLE, HDR_LO, HDR_HI, DATA, PATCH, KBD, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR_LO, HDR_HI, DATA, PATCH, DONE} state_t;
`endif
  localparam logic [7:0] PTR_BASE_DEF = 8'h2A;
  localparam logic [15:0] RAM_TOP_DEF = 16'h8000;
  localparam logic [2:0] PATCH_LAST = 3'd5;
`ifdef PRG_AUTORUN_EN
  localparam logic [14:0] KBD_BUF_ADDR = 15'h026F;
  localparam logic [14:0] KBD_CNT_ADDR = 15'h009E;
  localparam logic [7:0] KBD_CNT = 8'h04;
  localparam logic [7:0] RUN_R = 8'h52;
  localparam logic [7:0] RUN_U = 8'h55;
  localparam logic [7:0] RUN_N = 8'h4E;
  localparam logic [7:0] RUN_CR = 8'h0D;
  localparam logic [2:0] KBD_LAST = 3'd4;
  function automatic logic [7:0] kbd_byte(input logic [2:0] i);
    return i == KBD_LAST ? KBD_CNT : i[1:0] == 2'd0 ? RUN_R : i[1:0] == 2'd1 ? RUN_U : i[1:0] == 2'd2 ? RUN_N : RUN_CR;
  endfunction
`endif
endpackage

// File: rtl/pet2001_dma_wq.sv
// pet2001_dma_wq: one-entry DMA holding register; the entry drains the clk after it loads, so the source is held only while the loader owns the port
module pet2001_dma_wq (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        lock,
  input  logic [14:0] push_addr,
  input  logic [7:0]  push_data,
  output logic [14:0] dma_addr,
  output logic [7:0]  dma_din,
  output logic        dma_we,
  output logic        dl_wait
);
  logic [14:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic valid_q, valid_d;
  // load on push, otherwise keep address/data so the port holds its last values
  always_comb begin
    valid_d = push;
    addr_d = push ? push_addr : addr_q;
    data_d = push ? push_data : data_q;
  end
  // holding register
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
  assign dma_addr = addr_q;
  assign dma_din = data_q;
  assign dma_we = valid_q;
  assign dl_wait = lock;
endmodule

// File: rtl/pet2001_prg_loader.sv
// pet2001_prg_loader: streams a .PRG download into PET RAM and patches BASIC pointers (PRG_AUTORUN_EN also types RUN<CR>)
module pet2001_prg_loader
  import pet2001_loader_pkg::*;
#(
  parameter logic [7:0]  PTR_BASE = PTR_BASE_DEF,
  parameter logic [15:0] RAM_TOP  = RAM_TOP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [7:0]  dl_data,
  output logic        dl_wait,
  output logic [14:0] dma_addr,
  output logic [7:0]  dma_din,
  output logic        dma_we,
  output logic        busy,
  output logic        done,
  output logic        error
);
  state_t state_q, state_d;
  logic [15:0] load_addr_q, load_addr_d, end_q, end_d, target;
  logic [16:0] count_q, count_d, end_full;
  logic [2:0] idx_q, idx_d;
  logic error_q, error_d, active_q, active_d, rise, push, lock;
  logic [14:0] push_addr;
  logic [7:0] push_data;
  assign rise = dl_active & ~active_q;
  assign target = load_addr_q + count_q[15:0];
  assign end_full = {1'b0, load_addr_q} + count_q;
  // sequencing: header capture, payload writes, pointer patch, optional keyboard stuffing
  always_comb begin
    state_d = state_q;
    load_addr_d = load_addr_q;
    count_d = count_q;
    end_d = end_q;
    idx_d = idx_q;
    error_d = error_q;
    active_d = dl_active;
    push = 1'b0;
    lock = 1'b0;
    push_addr = target[14:0];
    push_data = dl_data;
    case (state_q)
      HDR_LO: begin
        if (!dl_active) begin
          error_d = 1'b1;
          state_d = DONE;
        end else if (dl_wr) begin
          load_addr_d[7:0] = dl_data;
          state_d = HDR_HI;
        end
      end
      HDR_HI: begin
        if (!dl_active) begin
          error_d = 1'b1;
          state_d = DONE;
        end else if (dl_wr) begin
          load_addr_d[15:8] = dl_data;
          state_d = DATA;
        end
      end
      DATA: begin
        if (!dl_active) begin
          end_d = end_full >= {1'b0, RAM_TOP} ? RAM_TOP : end_full[15:0];
          idx_d = '0;
          state_d = PATCH;
        end else if (dl_wr) begin
          count_d = count_q + 17'd1;
          push = target < RAM_TOP;
          error_d = error_q | (target >= RAM_TOP);
        end
      end
      PATCH: begin
        lock = 1'b1;
        push = 1'b1;
        push_addr = {7'd0, PTR_BASE} + {12'd0, idx_q};
        push_data = idx_q[0] ? end_q[15:8] : end_q[7:0];
        idx_d = idx_q == PATCH_LAST ? 3'd0 : idx_q + 3'd1;
        if (idx_q == PATCH_LAST) begin
`ifdef PRG_AUTORUN_EN
          state_d = error_q ? DONE : KBD;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef PRG_AUTORUN_EN
      KBD: begin
        lock = 1'b1;
        push = 1'b1;
        push_addr = idx_q == KBD_LAST ? KBD_CNT_ADDR : KBD_BUF_ADDR + {12'd0, idx_q};
        push_data = kbd_byte(idx_q);
        idx_d = idx_q + 3'd1;
        state_d = idx_q == KBD_LAST ? DONE : KBD;
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rise) begin
      state_d = HDR_LO;
      error_d = 1'b0;
      count_d = '0;
      idx_d = '0;
      push = 1'b0;
      lock = 1'b0;
    end
  end
  // control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      load_addr_q <= '0;
      count_q <= '0;
      end_q <= '0;
      idx_q <= '0;
      error_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q <= state_d;
      load_addr_q <= load_addr_d;
      count_q <= count_d;
      end_q <= end_d;
      idx_q <= idx_d;
      error_q <= error_d;
      active_q <= active_d;
    end
  end
  pet2001_dma_wq u_wq (
    .clk(clk),
    .reset(reset),
    .push(push),
    .lock(lock),
    .push_addr(push_addr),
    .push_data(push_data),
    .dma_addr(dma_addr),
    .dma_din(dma_din),
    .dma_we(dma_we),
    .dl_wait(dl_wait)
  );
  assign busy = state_q != IDLE && state_q != DONE;
  assign done = state_q == DONE;
  assign error = error_q;
endmodule
